// File: rtl/vend_dispenser_if.sv
// Signal bundle between the vending FSM side and the dispenser: event inputs,
// sensor/clear inputs, actuator drives and status, plus the dispenser state for debug.
interface vend_dispenser_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  // out/change are level events sampled on every rising edge with no ready path:
  // each edge with out=1 or change!=00 is one event, and a full FIFO drops it and sets overflow.
  logic          out;
  logic [1:0]    change;
  logic          prod_sense;
  logic          fault_clr;
  logic          prod_motor;
  logic          coin5_eject;
  logic          coin10_eject;
  logic          busy;
  logic [CW-1:0] pending;
  logic          overflow;
  logic          fault;
  logic [2:0]    state;

  modport master (
    output out, change, prod_sense, fault_clr,
    input  prod_motor, coin5_eject, coin10_eject, busy, pending, overflow, fault, state
  );

  modport slave (
    input  out, change, prod_sense, fault_clr,
    output prod_motor, coin5_eject, coin10_eject, busy, pending, overflow, fault, state
  );
endinterface

// File: rtl/vend_dispenser.sv
// Queues vend/change events and sequences the product motor and coin ejectors,
// with product-drop confirmation, timeout fault and sticky overflow flag.
module vend_dispenser #(
  parameter int DEPTH       = 4,
  parameter int PULSE_CYC   = 4,
  parameter int GAP_CYC     = 2,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic             clk,
  input  logic             rst,
  vend_dispenser_if.slave  bus
);
  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = $clog2(DEPTH + 1);
  localparam int TMAX = (TIMEOUT_CYC > PULSE_CYC) ?
                        ((TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC) :
                        ((PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC);
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PROD_ON   = 3'd1,
    PROD_WAIT = 3'd2,
    COIN_ON   = 3'd3,
    COIN_GAP  = 3'd4,
    FAULT     = 3'd5
  } state_t;

  state_t        state, state_nx;
  logic [TW-1:0] timer, timer_nx;
  logic [1:0]    rem, rem_nx;

  logic [2:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;

  logic          push_req, push, pop, full;
  logic [2:0]    head;
  logic          pulse_done, gap_done, timeout_done;

  assign push_req = bus.out | (|bus.change);
  assign full     = (count == CW'(DEPTH));
  assign pop      = (state == IDLE) && (count != '0);
  // A pop on the same edge frees the slot the incoming event needs.
  assign push     = push_req && (!full || pop);
  assign head     = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.out, bus.change};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push_req && !push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      timer <= '0;
      rem   <= '0;
    end else begin
      state <= state_nx;
      timer <= timer_nx;
      rem   <= rem_nx;
    end
  end

  assign pulse_done   = (timer == TW'(PULSE_CYC - 1));
  assign gap_done     = (timer == TW'(GAP_CYC - 1));
  assign timeout_done = (timer == TW'(TIMEOUT_CYC - 1));

  // rem holds the coins still owed for the entry in service; coin10 is always served first.
  always_comb begin
    state_nx = state;
    rem_nx   = rem;
    case (state)
      IDLE: begin
        if (pop) begin
          rem_nx = head[1:0];
          if (head[2])                 state_nx = PROD_ON;
          else if (head[1:0] != 2'b00) state_nx = COIN_ON;
        end
      end
      PROD_ON: begin
        if (pulse_done) state_nx = PROD_WAIT;
      end
      PROD_WAIT: begin
        if (bus.prod_sense)    state_nx = (rem != 2'b00) ? COIN_ON : IDLE;
        else if (timeout_done) state_nx = FAULT;
      end
      COIN_ON: begin
        if (pulse_done) begin
          state_nx = COIN_GAP;
          rem_nx   = rem[1] ? {1'b0, rem[0]} : 2'b00;
        end
      end
      COIN_GAP: begin
        if (gap_done) state_nx = (rem != 2'b00) ? COIN_ON : IDLE;
      end
      FAULT: begin
        if (bus.fault_clr) begin
          state_nx = IDLE;
          rem_nx   = 2'b00;
        end
      end
      default: state_nx = IDLE;
    endcase
    timer_nx = (state_nx != state || state == IDLE || state == FAULT) ? '0 : timer + TW'(1);
  end

  always_comb begin
    bus.prod_motor   = (state == PROD_ON);
    bus.coin10_eject = (state == COIN_ON) && rem[1];
    bus.coin5_eject  = (state == COIN_ON) && !rem[1];
    bus.busy         = (state != IDLE);
    bus.fault        = (state == FAULT);
    bus.pending      = count;
    bus.overflow     = overflow;
    bus.state        = state;
  end
endmodule
